// File: rtl/flu_frame_arbiter.sv
// Round-robin merge of several FLU RX streams into one registered FLU TX stream.
// Arbitration happens only between frames, so a granted input keeps the output until its frame ends.
module flu_frame_arbiter #(
  parameter int INPUTS        = 2,
  parameter int DATA_WIDTH    = 512,
  parameter int SOP_POS_WIDTH = 3,
  parameter int EOP_POS_WIDTH = $clog2(DATA_WIDTH/8),
  parameter int SEL_WIDTH     = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [INPUTS*DATA_WIDTH-1:0]      RX_DATA,
  input  logic [INPUTS*SOP_POS_WIDTH-1:0]   RX_SOP_POS,
  input  logic [INPUTS*EOP_POS_WIDTH-1:0]   RX_EOP_POS,
  input  logic [INPUTS-1:0]                 RX_SOP,
  input  logic [INPUTS-1:0]                 RX_EOP,
  input  logic [INPUTS-1:0]                 RX_SRC_RDY,
  output logic [INPUTS-1:0]                 RX_DST_RDY,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic [SOP_POS_WIDTH-1:0]          TX_SOP_POS,
  output logic [EOP_POS_WIDTH-1:0]          TX_EOP_POS,
  output logic                              TX_SOP,
  output logic                              TX_EOP,
  output logic                              TX_SRC_RDY,
  input  logic                              TX_DST_RDY,
  input  logic [INPUTS-1:0]                 EN,
  output logic [SEL_WIDTH-1:0]              GRANT,
  output logic                              GRANT_VLD
);

  localparam int BLK = (DATA_WIDTH/8) >> SOP_POS_WIDTH;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [SEL_WIDTH-1:0]     sel_q, sel_d;
  logic [SEL_WIDTH-1:0]     last_q, last_d;
  logic [SEL_WIDTH-1:0]     rr_pick;

  logic [DATA_WIDTH-1:0]    tx_data_q;
  logic [SOP_POS_WIDTH-1:0] tx_sop_pos_q;
  logic [EOP_POS_WIDTH-1:0] tx_eop_pos_q;
  logic                     tx_sop_q, tx_eop_q, tx_src_rdy_q;

  logic [DATA_WIDTH-1:0]    rx_data_a    [INPUTS];
  logic [SOP_POS_WIDTH-1:0] rx_sop_pos_a [INPUTS];
  logic [EOP_POS_WIDTH-1:0] rx_eop_pos_a [INPUTS];

  logic [INPUTS-1:0]        req;
  logic                     locked, ld, xfer;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [SOP_POS_WIDTH-1:0] sel_sop_pos;
  logic [EOP_POS_WIDTH-1:0] sel_eop_pos;
  logic                     sel_sop, sel_eop, sel_src_rdy, sel_trail;

  // A trailing SOP means another frame begins in the same word, after the EOP byte.
  function automatic logic trail_f(input logic sop, input logic eop,
                                   input logic [SOP_POS_WIDTH-1:0] sop_pos,
                                   input logic [EOP_POS_WIDTH-1:0] eop_pos);
    int unsigned start_byte;
    start_byte = 32'(sop_pos) * 32'(BLK);
    return sop & eop & (start_byte > 32'(eop_pos));
  endfunction

  function automatic logic [SEL_WIDTH-1:0] rr_pick_f(input logic [INPUTS-1:0] r,
                                                     input logic [SEL_WIDTH-1:0] last);
    logic [SEL_WIDTH-1:0] pick;
    logic [SEL_WIDTH-1:0] idx;
    logic                 hit;
    pick = last;
    hit  = 1'b0;
    for (int k = 1; k <= INPUTS; k++) begin
      idx = SEL_WIDTH'((int'(last) + k) % INPUTS);
      if (!hit && r[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < INPUTS; g++) begin : g_split
    assign rx_data_a[g]    = RX_DATA[g*DATA_WIDTH +: DATA_WIDTH];
    assign rx_sop_pos_a[g] = RX_SOP_POS[g*SOP_POS_WIDTH +: SOP_POS_WIDTH];
    assign rx_eop_pos_a[g] = RX_EOP_POS[g*EOP_POS_WIDTH +: EOP_POS_WIDTH];
  end

  assign req         = RX_SRC_RDY & EN;
  assign rr_pick     = rr_pick_f(req, last_q);
  assign locked      = (state_q == ST_LOCKED);

  assign sel_data    = rx_data_a[sel_q];
  assign sel_sop_pos = rx_sop_pos_a[sel_q];
  assign sel_eop_pos = rx_eop_pos_a[sel_q];
  assign sel_sop     = RX_SOP[sel_q];
  assign sel_eop     = RX_EOP[sel_q];
  assign sel_src_rdy = RX_SRC_RDY[sel_q];
  assign sel_trail   = trail_f(sel_sop, sel_eop, sel_sop_pos, sel_eop_pos);

  // Output register can take a word when empty or being drained this cycle.
  assign ld   = !tx_src_rdy_q | TX_DST_RDY;
  assign xfer = locked & sel_src_rdy & ld;

  always_comb begin
    RX_DST_RDY = '0;
    if (locked) begin
      RX_DST_RDY[sel_q] = ld;
    end
  end

  // Arbitration state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_WIDTH'(INPUTS-1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (state_q == ST_IDLE) begin
      if (|req) begin
        state_d = ST_LOCKED;
        sel_d   = rr_pick;
        last_d  = rr_pick;
      end
    end else if (xfer && sel_eop && !sel_trail) begin
      state_d = ST_IDLE;
    end
  end

  // Output register stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_src_rdy_q <= 1'b0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
      tx_data_q    <= '0;
      tx_sop_pos_q <= '0;
      tx_eop_pos_q <= '0;
    end else if (ld) begin
      tx_src_rdy_q <= xfer;
      if (xfer) begin
        tx_sop_q     <= sel_sop;
        tx_eop_q     <= sel_eop;
        tx_data_q    <= sel_data;
        tx_sop_pos_q <= sel_sop_pos;
        tx_eop_pos_q <= sel_eop_pos;
      end
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_SOP_POS = tx_sop_pos_q;
  assign TX_EOP_POS = tx_eop_pos_q;
  assign TX_SOP     = tx_sop_q;
  assign TX_EOP     = tx_eop_q;
  assign TX_SRC_RDY = tx_src_rdy_q;
  assign GRANT      = sel_q;
  assign GRANT_VLD  = locked;

endmodule

// File: tb/tb_flu_frame_arbiter.sv
// Scoreboard bench for flu_frame_arbiter: per-input source queues feed RX, a monitor
// compares every accepted TX word against the expected queue filled by the directed tests.
module tb_flu_frame_arbiter;

  localparam int N   = 4;
  localparam int DW  = 512;
  localparam int SPW = 3;
  localparam int EPW = 6;
  localparam int SW  = 2;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N*DW-1:0] RX_DATA;
  logic [N*SPW-1:0] RX_SOP_POS;
  logic [N*EPW-1:0] RX_EOP_POS;
  logic [N-1:0]    RX_SOP, RX_EOP, RX_SRC_RDY, RX_DST_RDY, EN;
  logic [DW-1:0]   TX_DATA;
  logic [SPW-1:0]  TX_SOP_POS;
  logic [EPW-1:0]  TX_EOP_POS;
  logic            TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY;
  logic [SW-1:0]   GRANT;
  logic            GRANT_VLD;

  flu_frame_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
    .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
    .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
    .EN(EN), .GRANT(GRANT), .GRANT_VLD(GRANT_VLD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0]  data;
    logic [SPW-1:0] sp;
    logic [EPW-1:0] ep;
    logic           sop;
    logic           eop;
  } word_t;

  word_t        srcq [N][$];
  word_t        expq [$];
  logic [N-1:0] acc;
  int           checks = 0;
  int           errors = 0;

  // Backpressure table, index = cycle after the frame is queued (0 unused).
  int bp_dst  [14] = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
  int bp_txv  [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int bp_word [14] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int bp_rdy  [14] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};

  function automatic logic [DW-1:0] mkdata(int i, int f, int w);
    logic [31:0] t;
    t = {8'(i), 8'(f), 16'(w)};
    return {16{t}};
  endfunction

  function automatic word_t mkword(int i, int f, int w, logic sop, logic eop, int sp, int ep);
    word_t x;
    x.data = mkdata(i, f, w);
    x.sp   = SPW'(sp);
    x.ep   = EPW'(ep);
    x.sop  = sop;
    x.eop  = eop;
    return x;
  endfunction

  function automatic logic any_src();
    logic a;
    a = 1'b0;
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) a = 1'b1;
    return a;
  endfunction

  task automatic src_frame(int i, int f, int n);
    for (int w = 0; w < n; w++) srcq[i].push_back(mkword(i, f, w, w == 0, w == n-1, 0, 63));
  endtask

  task automatic exp_frame(int i, int f, int n);
    for (int w = 0; w < n; w++) expq.push_back(mkword(i, f, w, w == 0, w == n-1, 0, 63));
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event expected event", name);
  endtask

  task automatic drive_rx();
    word_t w;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() != 0) begin
        w = srcq[i][0];
        RX_DATA[i*DW +: DW]      = w.data;
        RX_SOP_POS[i*SPW +: SPW] = w.sp;
        RX_EOP_POS[i*EPW +: EPW] = w.ep;
        RX_SOP[i]     = w.sop;
        RX_EOP[i]     = w.eop;
        RX_SRC_RDY[i] = 1'b1;
      end else begin
        RX_DATA[i*DW +: DW]      = '0;
        RX_SOP_POS[i*SPW +: SPW] = '0;
        RX_EOP_POS[i*EPW +: EPW] = '0;
        RX_SOP[i]     = 1'b0;
        RX_EOP[i]     = 1'b0;
        RX_SRC_RDY[i] = 1'b0;
      end
    end
  endtask

  task automatic driver_loop();
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
      end
      drive_rx();
    end
  endtask

  task automatic monitor_loop();
    word_t w;
    forever begin
      @(negedge CLK);
      acc = RX_SRC_RDY & RX_DST_RDY;
      if (!RESET && TX_SRC_RDY && TX_DST_RDY) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got word %0h expected no word", TX_DATA[31:0]);
        end else begin
          w = expq.pop_front();
          chk("tx_word", {TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS, TX_DATA},
                         {w.sop, w.eop, w.sp, w.ep, w.data});
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || any_src()) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) timeout(name);
    else begin
      repeat (3) @(negedge CLK);
      chk({name, "_idle"}, DW'(GRANT_VLD), DW'(0));
    end
  endtask

  task automatic wait_gvld(input string name);
    int n;
    n = 0;
    while (!GRANT_VLD && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) timeout(name);
  endtask

  initial begin
    int n;
    logic [5:0] txp, gvp;
    RESET = 1'b1;
    TX_DST_RDY = 1'b1;
    EN = '1;
    acc = '0;
    drive_rx();
    fork
      driver_loop();
      monitor_loop();
    join_none

    repeat (2) @(negedge CLK);
    chk("rst_tx_src_rdy", DW'(TX_SRC_RDY), DW'(0));
    chk("rst_tx_sop", DW'(TX_SOP), DW'(0));
    chk("rst_tx_eop", DW'(TX_EOP), DW'(0));
    chk("rst_tx_data", TX_DATA, DW'(0));
    chk("rst_tx_pos", DW'({TX_SOP_POS, TX_EOP_POS}), DW'(0));
    chk("rst_rx_dst_rdy", DW'(RX_DST_RDY), DW'(0));
    chk("rst_grant", DW'(GRANT), DW'(0));
    chk("rst_grant_vld", DW'(GRANT_VLD), DW'(0));
    RESET = 1'b0;

    // Contention: two 2-word frames per input, round-robin from input 0.
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      src_frame(i, 0, 2);
      src_frame(i, 1, 2);
    end
    for (int f = 0; f < 2; f++) for (int i = 0; i < N; i++) exp_frame(i, f, 2);
    n = 0;
    while (!TX_SRC_RDY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) timeout("cont_first_tx");
    else begin
      for (int s = 0; s < 23; s++) begin
        chk("cont_bubble", DW'(TX_SRC_RDY), DW'(s % 3 != 2));
        @(negedge CLK);
      end
    end
    wait_drain("cont");

    // Single input 2, 3-word frame.
    txp = 6'b011100;
    gvp = 6'b001110;
    src_frame(2, 2, 3);
    exp_frame(2, 2, 3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      chk("single_tx_vld", DW'(TX_SRC_RDY), DW'(txp[c-1]));
      chk("single_gvld", DW'(GRANT_VLD), DW'(gvp[c-1]));
      if (c == 2) begin
        chk("single_grant", DW'(GRANT), DW'(2));
        chk("single_rx_rdy", DW'(RX_DST_RDY), DW'(4'b0100));
      end
    end
    wait_drain("single");

    // Trailing SOP on input 1 keeps the grant while input 0 waits.
    srcq[1].push_back(mkword(1, 3, 0, 1'b1, 1'b1, 2, 13));
    srcq[1].push_back(mkword(1, 3, 1, 1'b0, 1'b0, 0, 63));
    srcq[1].push_back(mkword(1, 3, 2, 1'b0, 1'b1, 0, 63));
    expq.push_back(mkword(1, 3, 0, 1'b1, 1'b1, 2, 13));
    expq.push_back(mkword(1, 3, 1, 1'b0, 1'b0, 0, 63));
    expq.push_back(mkword(1, 3, 2, 1'b0, 1'b1, 0, 63));
    @(negedge CLK);
    srcq[0].push_back(mkword(0, 3, 0, 1'b1, 1'b1, 0, 63));
    expq.push_back(mkword(0, 3, 0, 1'b1, 1'b1, 0, 63));
    repeat (3) @(negedge CLK);
    chk("trail_gvld", DW'(GRANT_VLD), DW'(1));
    chk("trail_grant", DW'(GRANT), DW'(1));
    wait_drain("trail");

    // Single-word frame on input 3, then the SOP_POS*BLK == EOP_POS boundary.
    srcq[3].push_back(mkword(3, 4, 0, 1'b1, 1'b1, 0, 40));
    expq.push_back(mkword(3, 4, 0, 1'b1, 1'b1, 0, 40));
    repeat (2) @(negedge CLK);
    chk("sw_gvld", DW'(GRANT_VLD), DW'(1));
    chk("sw_grant", DW'(GRANT), DW'(3));
    @(negedge CLK);
    chk("sw_tx_vld", DW'(TX_SRC_RDY), DW'(1));
    chk("sw_back_idle", DW'(GRANT_VLD), DW'(0));
    wait_drain("sw");
    srcq[3].push_back(mkword(3, 5, 0, 1'b1, 1'b1, 5, 40));
    expq.push_back(mkword(3, 5, 0, 1'b1, 1'b1, 5, 40));
    wait_drain("sw_boundary");

    // Backpressure: 4-word frame on input 1 with TX_DST_RDY 1,0,0,1,...
    src_frame(1, 6, 4);
    exp_frame(1, 6, 4);
    for (int c = 1; c <= 13; c++) begin
      @(posedge CLK);
      #1 TX_DST_RDY = bp_dst[c][0];
      @(negedge CLK);
      if (c >= 3) begin
        chk("bp_tx_vld", DW'(TX_SRC_RDY), DW'(bp_txv[c]));
        chk("bp_rx_rdy", DW'(RX_DST_RDY), (bp_rdy[c] != 0) ? DW'(4'b0010) : DW'(0));
        if (bp_txv[c] != 0) chk("bp_tx_data", TX_DATA, mkdata(1, 6, bp_word[c]));
      end
    end
    TX_DST_RDY = 1'b1;
    wait_drain("bp");

    // EN=1010: inputs 0 and 2 wait until re-enabled.
    EN = 4'b1010;
    for (int i = 0; i < N; i++) src_frame(i, 8, 2);
    exp_frame(3, 8, 2);
    exp_frame(1, 8, 2);
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) timeout("en_mask");
    repeat (5) begin
      @(negedge CLK);
      chk("en_masked_idle", DW'(GRANT_VLD), DW'(0));
    end
    EN = 4'b1111;
    exp_frame(2, 8, 2);
    exp_frame(0, 8, 2);
    wait_drain("en_restore");

    // Clearing EN[1] mid-frame lets the frame finish.
    src_frame(1, 9, 3);
    src_frame(3, 9, 1);
    exp_frame(1, 9, 3);
    exp_frame(3, 9, 1);
    wait_gvld("en_clear_grant");
    chk("en_clear_grant", DW'(GRANT), DW'(1));
    @(negedge CLK);
    EN = 4'b1101;
    wait_drain("en_clear");
    EN = 4'b1111;

    // Reset mid-frame, then input 0 must win over input 3.
    src_frame(1, 10, 4);
    exp_frame(1, 10, 4);
    wait_gvld("rst_mid_grant");
    repeat (2) @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("rstm_tx_src_rdy", DW'(TX_SRC_RDY), DW'(0));
    chk("rstm_tx_sop_eop", DW'({TX_SOP, TX_EOP}), DW'(0));
    chk("rstm_tx_data", TX_DATA, DW'(0));
    chk("rstm_rx_dst_rdy", DW'(RX_DST_RDY), DW'(0));
    chk("rstm_grant", DW'({GRANT, GRANT_VLD}), DW'(0));
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    src_frame(3, 11, 1);
    src_frame(0, 11, 1);
    exp_frame(0, 11, 1);
    exp_frame(3, 11, 1);
    wait_drain("rst_prio");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
